// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: RV32I decode-stage controller.
// Opcode decode, ID/EX control bundle, hazard sequencing, hazard counter.
module id_stage_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr_i,
   input  logic             instr_valid_i,
   input  logic             stall_i,
   input  logic             branch_taken_i,
   output logic [2:0]       imm_sel_o,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_valid_o,
   output logic             idex_alu_src_o,
   output logic             idex_mem_read_o,
   output logic             idex_mem_write_o,
   output logic             idex_reg_write_o,
   output logic [1:0]       idex_wb_sel_o,
   output logic             idex_branch_o,
   output logic             idex_jump_o,
   output logic [4:0]       idex_rd_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] hazard_cnt_o
);

   // Immediate_Unit Imm_Sel codes (R-type uses the default 0)
   localparam logic [2:0] IMM_R = 3'd0;
   localparam logic [2:0] IMM_I = 3'd1;
   localparam logic [2:0] IMM_S = 3'd2;
   localparam logic [2:0] IMM_B = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;
   localparam logic [2:0] IMM_J = 3'd5;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   typedef struct packed {
      logic       valid;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       branch;
      logic       jump;
      logic [4:0] rd;
   } idex_t;

   typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

   state_t           state_q, state_d;
   idex_t            idex_q, idex_d, dec;
   logic             ill_q, ill_d;
   logic [CNT_W-1:0] cnt_q;
   logic             cnt_en;
   logic             legal, use_rs1, use_rs2, lu_haz;
   logic [6:0]       opc;
   logic [4:0]       rs1, rs2;
   logic             unused_bits;

   assign opc = instr_i[6:0];
   assign rs1 = instr_i[19:15];
   assign rs2 = instr_i[24:20];
   assign unused_bits = ^{instr_i[31:25], instr_i[14:12]};

   // Opcode decode into Imm_Sel, control bundle and source-register usage
   always_comb begin
      dec       = '0;
      imm_sel_o = IMM_R;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      legal     = 1'b1;
      unique case (1'b1)
         (opc == OP_R): begin
            dec.reg_write = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         (opc == OP_IALU): begin
            imm_sel_o = IMM_I;
            dec.alu_src = 1'b1;
            dec.reg_write = 1'b1;
            use_rs1 = 1'b1;
         end
         (opc == OP_LOAD): begin
            imm_sel_o = IMM_I;
            dec.mem_read = 1'b1;
            dec.wb_sel = 2'd1;
            dec.reg_write = 1'b1;
            use_rs1 = 1'b1;
         end
         (opc == OP_STORE): begin
            imm_sel_o = IMM_S;
            dec.mem_write = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         (opc == OP_BR): begin
            imm_sel_o = IMM_B;
            dec.branch = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         (opc == OP_LUI), (opc == OP_AUIPC): begin
            imm_sel_o = IMM_U;
            dec.reg_write = 1'b1;
         end
         (opc == OP_JAL): begin
            imm_sel_o = IMM_J;
            dec.jump = 1'b1;
            dec.wb_sel = 2'd2;
            dec.reg_write = 1'b1;
         end
         (opc == OP_JALR): begin
            imm_sel_o = IMM_I;
            dec.jump = 1'b1;
            dec.wb_sel = 2'd2;
            dec.reg_write = 1'b1;
            use_rs1 = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      if (legal) dec.rd = instr_i[11:7];
      dec.valid = instr_valid_i & legal;
      if (!dec.valid) dec = '0;
   end

   assign lu_haz = idex_q.valid & idex_q.mem_read & (|idex_q.rd)
                 & instr_valid_i
                 & ((use_rs1 & (rs1 == idex_q.rd))
                 |  (use_rs2 & (rs2 == idex_q.rd)));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Next state: stall holds, flush beats load-use
   always_comb begin
      state_d = RUN;
      if (stall_i)             state_d = state_q;
      else if (branch_taken_i) state_d = FLUSH;
      else if (lu_haz)         state_d = LU_STALL;
   end

   // Hazard outputs and next ID/EX contents for this cycle's decision
   always_comb begin
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      ifid_flush_o = 1'b0;
      idex_d       = dec;
      ill_d        = instr_valid_i & ~legal;
      cnt_en       = 1'b0;
      if (rst) begin
         idex_d = '0;
         ill_d  = 1'b0;
      end else if (stall_i) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         idex_d       = idex_q;
         ill_d        = 1'b0;
      end else if (state_d == FLUSH) begin
         ifid_flush_o = 1'b1;
         idex_d       = '0;
         ill_d        = 1'b0;
         cnt_en       = 1'b1;
      end else if (state_d == LU_STALL) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         idex_d       = '0;
         ill_d        = 1'b0;
         cnt_en       = 1'b1;
      end
   end

   // ID/EX register, illegal pulse and saturating hazard counter
   always_ff @(posedge clk) begin
      if (rst) begin
         idex_q <= '0;
         ill_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         idex_q <= idex_d;
         ill_q  <= ill_d;
         if (cnt_en && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign idex_valid_o     = idex_q.valid;
   assign idex_alu_src_o   = idex_q.alu_src;
   assign idex_mem_read_o  = idex_q.mem_read;
   assign idex_mem_write_o = idex_q.mem_write;
   assign idex_reg_write_o = idex_q.reg_write;
   assign idex_wb_sel_o    = idex_q.wb_sel;
   assign idex_branch_o    = idex_q.branch;
   assign idex_jump_o      = idex_q.jump;
   assign idex_rd_o        = idex_q.rd;
   assign illegal_o        = ill_q;
   assign hazard_cnt_o     = cnt_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// tb_id_stage_ctrl: scoreboard bench for id_stage_ctrl.
// Second instance with CNT_W=2 shares stimulus to exercise saturation.
module tb_id_stage_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, iv, st, br;
   logic [31:0] instr;

   logic [2:0]  imm_sel;
   logic        pcw, ifw, ifl, ill;
   logic        o_v, o_as, o_mr, o_mw, o_rw, o_b, o_j;
   logic [1:0]  o_wb;
   logic [4:0]  o_rd;
   logic [15:0] cnt;

   logic [2:0]  s_imm;
   logic        s_pcw, s_ifw, s_ifl, s_ill;
   logic        s_v, s_as, s_mr, s_mw, s_rw, s_b, s_j;
   logic [1:0]  s_wb;
   logic [4:0]  s_rd;
   logic [1:0]  cnt2;

   id_stage_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .instr_i(instr), .instr_valid_i(iv),
      .stall_i(st), .branch_taken_i(br), .imm_sel_o(imm_sel),
      .pc_write_o(pcw), .ifid_write_o(ifw), .ifid_flush_o(ifl),
      .idex_valid_o(o_v), .idex_alu_src_o(o_as),
      .idex_mem_read_o(o_mr), .idex_mem_write_o(o_mw),
      .idex_reg_write_o(o_rw), .idex_wb_sel_o(o_wb),
      .idex_branch_o(o_b), .idex_jump_o(o_j), .idex_rd_o(o_rd),
      .illegal_o(ill), .hazard_cnt_o(cnt)
   );

   id_stage_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .instr_i(instr), .instr_valid_i(iv),
      .stall_i(st), .branch_taken_i(br), .imm_sel_o(s_imm),
      .pc_write_o(s_pcw), .ifid_write_o(s_ifw), .ifid_flush_o(s_ifl),
      .idex_valid_o(s_v), .idex_alu_src_o(s_as),
      .idex_mem_read_o(s_mr), .idex_mem_write_o(s_mw),
      .idex_reg_write_o(s_rw), .idex_wb_sel_o(s_wb),
      .idex_branch_o(s_b), .idex_jump_o(s_j), .idex_rd_o(s_rd),
      .illegal_o(s_ill), .hazard_cnt_o(cnt2)
   );

   typedef struct packed {
      logic       v, as, mr, mw, rw;
      logic [1:0] wb;
      logic       b, j;
      logic [4:0] rd;
   } bun_t;

   typedef struct packed {
      bun_t        b;
      logic        ill;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   bun_t        obs;
   exp_t        q[$];
   bun_t        m_idex;
   logic [15:0] m_cnt;
   logic [1:0]  m_cnt2;
   int          n_vec = 0;
   int          n_bad = 0;

   assign obs = {o_v, o_as, o_mr, o_mw, o_rw, o_wb, o_b, o_j, o_rd};

   localparam logic [31:0] ADDI  = 32'h00500093;
   localparam logic [31:0] LW_X2 = 32'h0000A103;
   localparam logic [31:0] ADD_D = 32'h001101B3;
   localparam logic [31:0] LW_X0 = 32'h0000A003;
   localparam logic [31:0] ADD_0 = 32'h001001B3;
   localparam logic [31:0] LUI2  = 32'h00002137;
   localparam logic [31:0] SW    = 32'h0020A023;
   localparam logic [31:0] BEQ   = 32'h00208063;
   localparam logic [31:0] JAL   = 32'h008000EF;
   localparam logic [31:0] JALR  = 32'h000100E7;
   localparam logic [31:0] AUIPC = 32'h00000297;
   localparam logic [31:0] BAD   = 32'h0000007F;

   function automatic void ref_dec(input logic [31:0] x,
      output bun_t d, output logic [2:0] imm,
      output logic u1, output logic u2, output logic lg);
      d = '0; imm = 3'd0; u1 = 0; u2 = 0; lg = 1;
      case (x[6:0])
         7'h33: begin d.rw = 1; u1 = 1; u2 = 1; end
         7'h13: begin imm = 1; d.as = 1; d.rw = 1; u1 = 1; end
         7'h03: begin
            imm = 1; d.mr = 1; d.wb = 1; d.rw = 1; u1 = 1;
         end
         7'h23: begin imm = 2; d.mw = 1; u1 = 1; u2 = 1; end
         7'h63: begin imm = 3; d.b = 1; u1 = 1; u2 = 1; end
         7'h37, 7'h17: begin imm = 4; d.rw = 1; end
         7'h6F: begin imm = 5; d.j = 1; d.wb = 2; d.rw = 1; end
         7'h67: begin
            imm = 1; d.j = 1; d.wb = 2; d.rw = 1; u1 = 1;
         end
         default: lg = 0;
      endcase
      if (lg) d.rd = x[11:7];
   endfunction

   task automatic bump();
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
   endtask

   // one clock: drive, model, push, check combinational, pop and check
   task automatic cycle(input logic [31:0] x, input logic v,
                        input logic s, input logic b, input logic r);
      bun_t d;
      exp_t e;
      logic [2:0] imm;
      logic u1, u2, lg, haz, epc, eifw, efl;
      rst = r; instr = x; iv = v; st = s; br = b;
      ref_dec(x, d, imm, u1, u2, lg);
      haz = m_idex.v & m_idex.mr & (m_idex.rd != 0) & v
          & ((u1 & (x[19:15] == m_idex.rd))
          |  (u2 & (x[24:20] == m_idex.rd)));
      e = '0;
      {epc, eifw, efl} = 3'b110;
      if (r) begin
         m_idex = '0; m_cnt = '0; m_cnt2 = '0;
      end else if (s) begin
         {epc, eifw, efl} = 3'b000;
      end else if (b) begin
         efl = 1; m_idex = '0; bump();
      end else if (haz) begin
         {epc, eifw} = 2'b00; m_idex = '0; bump();
      end else begin
         m_idex = '0;
         if (v && lg) begin
            m_idex = d; m_idex.v = 1;
         end
         e.ill = v & ~lg;
      end
      e.b = m_idex; e.cnt = m_cnt; e.cnt2 = m_cnt2;
      q.push_back(e);
      @(negedge clk);
      n_vec++;
      if (imm_sel !== imm) begin
         n_bad++;
         $display("FAIL imm_sel: got %0d want %0d", imm_sel, imm);
      end
      n_vec++;
      if ({pcw, ifw, ifl} !== {epc, eifw, efl}) begin
         n_bad++;
         $display("FAIL pc/ifid ctl: got %b want %b",
                  {pcw, ifw, ifl}, {epc, eifw, efl});
      end
      @(posedge clk); #1;
      e = q.pop_front();
      n_vec++;
      if (obs !== e.b) begin
         n_bad++;
         $display("FAIL idex bundle: got %h want %h", obs, e.b);
      end
      n_vec++;
      if (ill !== e.ill) begin
         n_bad++;
         $display("FAIL illegal: got %b want %b", ill, e.ill);
      end
      n_vec++;
      if (cnt !== e.cnt || cnt2 !== e.cnt2) begin
         n_bad++;
         $display("FAIL hazard_cnt: got %0d/%0d want %0d/%0d",
                  cnt, cnt2, e.cnt, e.cnt2);
      end
   endtask

   task automatic test_reset();
      cycle(ADDI, 1, 0, 0, 1);
      n_vec++;
      if ({obs, cnt, ill} !== '0) begin
         n_bad++;
         $display("FAIL reset state: got %h/%0d/%b want 0",
                  obs, cnt, ill);
      end
   endtask

   task automatic test_addi();
      cycle(ADDI, 1, 0, 0, 0);
      n_vec++;
      if (!(o_v && o_as && o_rw && o_rd == 5'd1 && o_wb == 2'd0)) begin
         n_bad++;
         $display("FAIL addi issue: got %h want v/as/rw rd=1", obs);
      end
   endtask

   task automatic test_load_use();
      logic [15:0] c0;
      c0 = cnt;
      cycle(LW_X2, 1, 0, 0, 0);
      cycle(ADD_D, 1, 0, 0, 0);
      n_vec++;
      if (o_v !== 1'b0) begin
         n_bad++;
         $display("FAIL lu bubble: got v=%b want 0", o_v);
      end
      cycle(ADD_D, 1, 0, 0, 0);
      n_vec++;
      if (o_rd !== 5'd3 || cnt !== c0 + 16'd1) begin
         n_bad++;
         $display("FAIL lu issue: got rd=%0d cnt=%0d want 3/%0d",
                  o_rd, cnt, c0 + 16'd1);
      end
   endtask

   task automatic test_no_stall();
      cycle(LW_X0, 1, 0, 0, 0);
      cycle(ADD_0, 1, 0, 0, 0);
      cycle(LW_X2, 1, 0, 0, 0);
      cycle(LUI2, 1, 0, 0, 0);
   endtask

   task automatic test_flush_vs_lu();
      cycle(LW_X2, 1, 0, 0, 0);
      cycle(ADD_D, 1, 0, 1, 0);
      cycle(ADDI, 0, 0, 0, 0);
   endtask

   task automatic test_stall_branch();
      logic [15:0] c0;
      cycle(LW_X2, 1, 0, 0, 0);
      c0 = cnt;
      for (int i = 0; i < 3; i++) cycle(ADD_D, 1, 1, 1, 0);
      n_vec++;
      if (cnt !== c0 || o_mr !== 1'b1) begin
         n_bad++;
         $display("FAIL stall freeze: got cnt=%0d mr=%b want %0d/1",
                  cnt, o_mr, c0);
      end
      cycle(ADD_D, 1, 0, 1, 0);
      cycle(ADDI, 1, 0, 0, 0);
   endtask

   task automatic test_illegal();
      cycle(BAD, 1, 0, 0, 0);
      cycle(ADDI, 1, 0, 0, 0);
      cycle(BAD, 0, 0, 0, 0);
      cycle(BAD, 1, 0, 1, 0);
      cycle(ADDI, 1, 0, 0, 0);
   endtask

   task automatic test_reset_abort();
      cycle(LW_X2, 1, 0, 0, 0);
      cycle(ADD_D, 1, 0, 0, 1);
      cycle(ADD_D, 0, 0, 0, 0);
      cycle(LW_X2, 1, 0, 0, 0);
      cycle(ADD_D, 1, 0, 1, 1);
      cycle(ADDI, 0, 0, 0, 0);
   endtask

   task automatic test_saturate();
      cycle(ADDI, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cycle(ADDI, 0, 0, 1, 0);
      n_vec++;
      if (cnt2 !== 2'd3 || cnt !== 16'd5) begin
         n_bad++;
         $display("FAIL saturate: got %0d/%0d want 3/5", cnt2, cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] tbl [0:11];
      tbl = '{ADDI, LW_X2, ADD_D, LW_X0, ADD_0, LUI2,
              SW, BEQ, JAL, JALR, AUIPC, BAD};
      for (int i = 0; i < 200; i++)
         cycle(tbl[$urandom_range(0, 11)],
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) == 0, 1'b0);
   endtask

   initial begin
      rst = 1; instr = '0; iv = 0; st = 0; br = 0;
      m_idex = '0; m_cnt = '0; m_cnt2 = '0;
      @(posedge clk); #1;
      test_reset();
      test_addi();
      test_load_use();
      test_no_stall();
      test_flush_vs_lu();
      test_stall_branch();
      test_illegal();
      test_reset_abort();
      test_saturate();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
- Decode-stage controller for the RV32I pipeline.
- Decodes the IF/ID instruction opcode into the Imm_Sel code that drives Immediate_Unit, and builds the control bundle held in the ID/EX pipeline register.
- Sequences pipeline hazards: load-use stall (one bubble), taken-branch/jump flush, and external memory-wait hold.
- Keeps a saturating count of cycles lost to hazards.

Parameters:
- CNT_W, 16, width of the hazard-cycle counter

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous reset, active-high
- instr_i  input  32  IF/ID instruction
- instr_valid_i  input  1  IF/ID holds a real instruction
- stall_i  input  1  memory wait; freeze whole pipeline
- branch_taken_i  input  1  EX resolved taken branch or jump (from the ID/EX entry)
- imm_sel_o  output  3  to Immediate_Unit Imm_Sel (`Itype/`Stype/`Btype/`Utype/`Jtype macros of parameter_define.sv)
- pc_write_o  output  1  PC may update
- ifid_write_o  output  1  IF/ID may load
- ifid_flush_o  output  1  IF/ID loads a bubble
- idex_valid_o  output  1  ID/EX entry valid
- idex_alu_src_o  output  1  1 = ALU operand B from immediate
- idex_mem_read_o  output  1  load
- idex_mem_write_o  output  1  store
- idex_reg_write_o  output  1  writes rd
- idex_wb_sel_o  output  2  0 ALU, 1 memory, 2 PC+4
- idex_branch_o  output  1  conditional branch
- idex_jump_o  output  1  JAL/JALR
- idex_rd_o  output  5  destination register
- illegal_o  output  1  one-cycle pulse, unknown opcode accepted
- hazard_cnt_o  output  CNT_W  saturating count of stall plus flush cycles

Behaviour:
- Decode is combinational on instr_i[6:0]:
  - 0110011 R: imm_sel default 0; uses rs1, rs2.
  - 0010011 I-ALU: `Itype, alu_src; uses rs1.
  - 0000011 load: `Itype, mem_read, wb=1; uses rs1.
  - 0100011 store: `Stype, mem_write, no reg_write; uses rs1, rs2.
  - 1100011 branch: `Btype, branch, no reg_write; uses rs1, rs2.
  - 0110111 LUI and 0010111 AUIPC: `Utype; no source registers.
  - 1101111 JAL: `Jtype, jump, wb=2; no source registers.
  - 1100111 JALR: `Itype, jump, wb=2; uses rs1.
  - reg_write is set for R, I-ALU, load, U, JAL, JALR.
  - Any other opcode is illegal: bundle is all-zero (bubble), illegal_o=1.
  - imm_sel_o follows instr_i every cycle, regardless of valid.
- Load-use hazard = idex_valid_o & idex_mem_read_o & idex_rd_o!=0 & instr_valid_i & (rs1 used & rs1==idex_rd_o | rs2 used & rs2==idex_rd_o). No external load/rd inputs: the compare uses the block's own ID/EX register.
- FSM states:
  - RUN: normal.
  - LU_STALL: one cycle. pc_write=0, ifid_write=0, ID/EX loads a bubble. Returns to RUN next cycle; no re-detect, because ID/EX now holds the bubble.
  - FLUSH: entered when branch_taken_i=1. ifid_flush_o=1, ID/EX loads a bubble, pc_write=1. Returns to RUN next cycle.
- Priority (highest first): rst > stall_i > branch_taken_i > load-use > RUN.
  - stall_i=1: all registers and state hold, pc_write=0, ifid_write=0, ifid_flush=0, counter holds.
  - A branch_taken_i asserted while stalled acts on the first cycle stall_i=0; EX keeps it asserted until then.
- Flush has priority over a simultaneous load-use hazard; the stall is dropped because the younger instruction is squashed.
- ID/EX load in RUN: decoded bundle with valid = instr_valid_i & legal. An invalid instruction loads a bubble.
- Outputs derived from FSM state are registered, so the first hazard cycle is visible one cycle after detection. The hazard decision itself drives pc_write/ifid_write combinationally in the detecting cycle.
- illegal_o pulses only when the illegal instruction is accepted (valid, not stalled, not flushed).
- hazard_cnt_o increments on each LU_STALL or FLUSH cycle and saturates at all-ones.
- Reset, synchronous: all idex_* outputs 0, state RUN, hazard_cnt_o=0, illegal_o=0, pc_write_o=1, ifid_write_o=1, ifid_flush_o=0.
  - Reset asserted mid-stall or mid-flush aborts it, and the next cycle is RUN with an empty ID/EX.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) valid -> imm_sel=`Itype; next cycle idex_valid=1, alu_src=1, reg_write=1, rd=1, wb_sel=0; hazard_cnt=0.
- lw x2,0(x1) then add x3,x2,x1 -> one cycle pc_write=0 and ifid_write=0, ID/EX bubble, add issues the cycle after; hazard_cnt=1.
- lw x0,0(x1) then add x3,x0,x1 -> no stall (rd=0); lui x2 after lw x2 -> no stall (no source registers).
- branch_taken_i=1 in the same cycle as a load-use hazard -> ifid_flush=1, pc_write=1, ID/EX bubble, no stall cycle; hazard_cnt +1.
- stall_i=1 for 3 cycles with branch_taken_i=1 -> outputs frozen, counter frozen; flush occurs on the cycle stall_i drops.
- Opcode 0x7F valid -> illegal_o pulse, idex_valid=0; CNT_W=2 with 5 hazards -> hazard_cnt=3.
